// File: rtl/tpu_acc_pkg.sv
// Shared types, lane masks and the saturating adder for the accumulator bank.
package tpu_acc_pkg;

  // Lane width the saturating adder is built for; the bank's DATA_W must match.
  localparam int ACC_DATA_W = 32;

  typedef enum logic [0:0] {
    ACC_IDLE  = 1'b0,
    ACC_CLEAR = 1'b1
  } acc_state_t;

  // Lane write masks, bit 0 = lane0, bit 1 = lane1.
  localparam logic [1:0] LANE_COL01 = 2'b11;
  localparam logic [1:0] LANE_COL2  = 2'b01;

  typedef struct packed {
    logic                  sat;
    logic [ACC_DATA_W-1:0] val;
  } sat_res_t;

  // Signed add clamped to the representable range; sat flags a clamp.
  function automatic sat_res_t sat_add(input logic [ACC_DATA_W-1:0] a,
                                       input logic [ACC_DATA_W-1:0] b);
    logic [ACC_DATA_W:0] sum;
    sat_res_t            res;
    sum = {a[ACC_DATA_W-1], a} + {b[ACC_DATA_W-1], b};
    if (sum[ACC_DATA_W] != sum[ACC_DATA_W-1]) begin
      res.sat = 1'b1;
      res.val = sum[ACC_DATA_W] ? {1'b1, {(ACC_DATA_W-1){1'b0}}}
                                : {1'b0, {(ACC_DATA_W-1){1'b1}}};
    end else begin
      res.sat = 1'b0;
      res.val = sum[ACC_DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_mem_2p.sv
// Two-lane dual-port RAM: port A reads one address and writes another
// (read-modify-write and clear), port B is a read port with enable so its
// output register holds while the consumer stalls.
module acc_mem_2p #(
  parameter int LANE_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                  clk,
  input  logic [1:0]            a_we,
  input  logic [IDX_W-1:0]      a_waddr,
  input  logic [2*LANE_W-1:0]   a_wdata,
  input  logic [IDX_W-1:0]      a_raddr,
  output logic [2*LANE_W-1:0]   a_rdata,
  input  logic                  b_en,
  input  logic [IDX_W-1:0]      b_addr,
  output logic [2*LANE_W-1:0]   b_rdata
);

  logic [2*LANE_W-1:0] mem_r [DEPTH];

  // Per-lane write on port A plus registered reads on both ports.
  always_ff @(posedge clk) begin
    if (a_we[0]) begin
      mem_r[a_waddr][LANE_W-1:0] <= a_wdata[LANE_W-1:0];
    end
    if (a_we[1]) begin
      mem_r[a_waddr][2*LANE_W-1:LANE_W] <= a_wdata[2*LANE_W-1:LANE_W];
    end
    a_rdata <= mem_r[a_raddr];
    if (b_en) begin
      b_rdata <= mem_r[b_addr];
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// Accumulator bank: two-lane entries written by the systolic controller
// through a 2-stage read-modify-write pipeline (overwrite or saturating
// accumulate), a full zero sweep on acc_clear, and a valid/ready read port.
module accumulator_bank
  import tpu_acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                acc_wr_en,
  input  logic [ADDR_W-1:0]   acc_wr_addr,
  input  logic                acc_wr_col01,
  input  logic                acc_wr_col2,
  input  logic                acc_clear,
  input  logic                acc_accumulate,
  input  logic [DATA_W-1:0]   col0_psum,
  input  logic [DATA_W-1:0]   col1_psum,
  input  logic [DATA_W-1:0]   col2_psum,
  input  logic                rd_req_valid,
  input  logic [ADDR_W-1:0]   rd_req_addr,
  output logic                rd_req_ready,
  output logic                rd_data_valid,
  output logic [2*DATA_W-1:0] rd_data,
  input  logic                rd_data_ready,
  output logic                acc_busy,
  output logic                clear_done,
  output logic                wr_drop,
  output logic                sat_flag,
  input  logic                err_clr
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [2*DATA_W-1:0] ZERO_E  = {(2*DATA_W){1'b0}};

  // Clear FSM
  acc_state_t        state_r;
  logic [IDX_W-1:0]  sweep_cnt_r;
  logic              busy_r;
  logic              clear_done_r;
  logic              clear_q_r;

  // W2 stage
  logic              w2_valid_r;
  logic [IDX_W-1:0]  w2_addr_r;
  logic [1:0]        w2_mask_r;
  logic [DATA_W-1:0] w2_lane0_r;
  logic [DATA_W-1:0] w2_lane1_r;
  logic              w2_mode_r;
  logic              w2_fwd_r;
  logic [2*DATA_W-1:0] w2_fwd_data_r;

  // Read port
  logic              rd_valid_r;
  logic              rd_zero_r;
  logic              rd_fwd_r;
  logic [2*DATA_W-1:0] rd_fwd_data_r;

  // Sticky flags
  logic              wr_drop_r;
  logic              sat_flag_r;

  // Combinational
  logic              wr_sel_ok_s;
  logic              wr_addr_ok_s;
  logic              wr_accept_s;
  logic              wr_bad_s;
  logic              w2_commit_s;
  logic [2*DATA_W-1:0] old_entry_s;
  sat_res_t          sum0_s;
  sat_res_t          sum1_s;
  logic [DATA_W-1:0] new0_s;
  logic [DATA_W-1:0] new1_s;
  logic [2*DATA_W-1:0] merged_s;
  logic              sat_hit_s;
  logic              rd_ready_s;
  logic              rd_accept_s;
  logic              rd_oob_s;
  logic              rd_hit_w2_s;
  logic [1:0]        a_we_s;
  logic [IDX_W-1:0]  a_waddr_s;
  logic [2*DATA_W-1:0] a_wdata_s;
  logic [2*DATA_W-1:0] a_rdata_s;
  logic              b_en_s;
  logic [2*DATA_W-1:0] b_rdata_s;

  // Write legality: exactly one lane group, in range, not during a sweep.
  always_comb begin
    wr_sel_ok_s  = acc_wr_col01 ^ acc_wr_col2;
    wr_addr_ok_s = ({1'b0, acc_wr_addr} < DEPTH_L);
    wr_accept_s  = acc_wr_en && wr_sel_ok_s && wr_addr_ok_s && !busy_r;
    wr_bad_s     = acc_wr_en && !wr_accept_s;
    // A W2 landing during a sweep is discarded; the sweep zeroes it anyway.
    w2_commit_s  = w2_valid_r && !busy_r;
  end

  // W2 lane math: forwarded or stored old entry, overwrite or saturating add.
  always_comb begin
    old_entry_s = w2_fwd_r ? w2_fwd_data_r : a_rdata_s;
    sum0_s      = sat_add(old_entry_s[DATA_W-1:0], w2_lane0_r);
    sum1_s      = sat_add(old_entry_s[2*DATA_W-1:DATA_W], w2_lane1_r);
    new0_s      = w2_mode_r ? sum0_s.val : w2_lane0_r;
    new1_s      = w2_mode_r ? sum1_s.val : w2_lane1_r;
    merged_s    = {(w2_mask_r[1] ? new1_s : old_entry_s[2*DATA_W-1:DATA_W]),
                   (w2_mask_r[0] ? new0_s : old_entry_s[DATA_W-1:0])};
    sat_hit_s   = w2_valid_r && w2_mode_r &&
                  ((w2_mask_r[0] && sum0_s.sat) || (w2_mask_r[1] && sum1_s.sat));
  end

  // Port A write mux: the sweep owns the port while busy, else W2 commits.
  always_comb begin
    if (busy_r) begin
      a_we_s    = 2'b11;
      a_waddr_s = sweep_cnt_r;
      a_wdata_s = ZERO_E;
    end else if (w2_commit_s) begin
      a_we_s    = w2_mask_r;
      a_waddr_s = w2_addr_r;
      a_wdata_s = merged_s;
    end else begin
      a_we_s    = 2'b00;
      a_waddr_s = w2_addr_r;
      a_wdata_s = merged_s;
    end
  end

  // Read handshake and address qualification.
  always_comb begin
    rd_ready_s  = !busy_r && (!rd_valid_r || rd_data_ready);
    rd_accept_s = rd_req_valid && rd_ready_s;
    rd_oob_s    = !({1'b0, rd_req_addr} < DEPTH_L);
    rd_hit_w2_s = w2_commit_s && (w2_addr_r == rd_req_addr[IDX_W-1:0]);
    b_en_s      = rd_accept_s && !rd_oob_s;
  end

  acc_mem_2p #(
    .LANE_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .a_we    (a_we_s),
    .a_waddr (a_waddr_s),
    .a_wdata (a_wdata_s),
    .a_raddr (acc_wr_addr[IDX_W-1:0]),
    .a_rdata (a_rdata_s),
    .b_en    (b_en_s),
    .b_addr  (rd_req_addr[IDX_W-1:0]),
    .b_rdata (b_rdata_s)
  );

  // Clear FSM: rising edge of acc_clear starts a DEPTH-cycle zero sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ACC_IDLE;
      sweep_cnt_r  <= {IDX_W{1'b0}};
      busy_r       <= 1'b0;
      clear_done_r <= 1'b0;
      clear_q_r    <= 1'b0;
    end else begin
      clear_q_r    <= acc_clear;
      clear_done_r <= 1'b0;
      case (state_r)
        ACC_IDLE: begin
          if (acc_clear && !clear_q_r) begin
            state_r     <= ACC_CLEAR;
            busy_r      <= 1'b1;
            sweep_cnt_r <= {IDX_W{1'b0}};
          end
        end
        ACC_CLEAR: begin
          if (sweep_cnt_r == LAST_IDX) begin
            state_r      <= ACC_IDLE;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b1;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ACC_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // W1 -> W2 capture, plus forwarding when W2 commits to the address W1 reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w2_valid_r    <= 1'b0;
      w2_addr_r     <= {IDX_W{1'b0}};
      w2_mask_r     <= 2'b00;
      w2_lane0_r    <= {DATA_W{1'b0}};
      w2_lane1_r    <= {DATA_W{1'b0}};
      w2_mode_r     <= 1'b0;
      w2_fwd_r      <= 1'b0;
      w2_fwd_data_r <= ZERO_E;
    end else begin
      w2_valid_r    <= wr_accept_s;
      w2_fwd_r      <= wr_accept_s && w2_commit_s &&
                       (w2_addr_r == acc_wr_addr[IDX_W-1:0]);
      w2_fwd_data_r <= merged_s;
      if (wr_accept_s) begin
        w2_addr_r  <= acc_wr_addr[IDX_W-1:0];
        w2_mask_r  <= acc_wr_col01 ? LANE_COL01 : LANE_COL2;
        w2_lane0_r <= acc_wr_col01 ? col0_psum : col2_psum;
        w2_lane1_r <= col1_psum;
        w2_mode_r  <= acc_accumulate;
      end
    end
  end

  // Read response: memory data, same-cycle W2 commit, or zero when out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r    <= 1'b0;
      rd_zero_r     <= 1'b1;
      rd_fwd_r      <= 1'b0;
      rd_fwd_data_r <= ZERO_E;
    end else if (rd_accept_s) begin
      rd_valid_r    <= 1'b1;
      rd_zero_r     <= rd_oob_s;
      rd_fwd_r      <= !rd_oob_s && rd_hit_w2_s;
      rd_fwd_data_r <= merged_s;
    end else if (rd_data_ready) begin
      rd_valid_r    <= 1'b0;
    end
  end

  // Sticky error flags; a new event beats a simultaneous err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_r  <= 1'b0;
      sat_flag_r <= 1'b0;
    end else begin
      if (wr_bad_s || (rd_accept_s && rd_oob_s)) begin
        wr_drop_r <= 1'b1;
      end else if (err_clr) begin
        wr_drop_r <= 1'b0;
      end
      if (sat_hit_s) begin
        sat_flag_r <= 1'b1;
      end else if (err_clr) begin
        sat_flag_r <= 1'b0;
      end
    end
  end

  assign rd_req_ready  = rd_ready_s;
  assign rd_data_valid = rd_valid_r;
  assign rd_data       = rd_zero_r ? ZERO_E : (rd_fwd_r ? rd_fwd_data_r : b_rdata_s);
  assign acc_busy      = busy_r;
  assign clear_done    = clear_done_r;
  assign wr_drop       = wr_drop_r;
  assign sat_flag      = sat_flag_r;

endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank: table of writes/reads plus hand sequences for
// clear, saturation, illegal writes, backpressure and read forwarding.
// Read expectations go into a queue and are checked as the data is consumed.
module tb_accumulator_bank;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          acc_wr_en, acc_wr_col01, acc_wr_col2, acc_clear, acc_accumulate;
  logic [AW-1:0] acc_wr_addr;
  logic [DW-1:0] col0_psum, col1_psum, col2_psum;
  logic          rd_req_valid, rd_req_ready, rd_data_valid, rd_data_ready;
  logic [AW-1:0] rd_req_addr;
  logic [2*DW-1:0] rd_data;
  logic          acc_busy, clear_done, wr_drop, sat_flag, err_clr;

  int n_vec = 0;
  int n_err = 0;
  logic [2*DW-1:0] exp_q [$];

  typedef struct {
    bit            rd;
    logic [AW-1:0] addr;
    bit            c01;
    bit            c2;
    bit            acc;
    logic [DW-1:0] p0, p1, p2;
    logic [2*DW-1:0] exp;
  } vec_t;
  vec_t tbl [$];

  accumulator_bank #(.DATA_W(DW), .DEPTH(256), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
    .acc_wr_col01(acc_wr_col01), .acc_wr_col2(acc_wr_col2), .acc_clear(acc_clear),
    .acc_accumulate(acc_accumulate), .col0_psum(col0_psum), .col1_psum(col1_psum),
    .col2_psum(col2_psum), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_ready(rd_req_ready), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .rd_data_ready(rd_data_ready), .acc_busy(acc_busy), .clear_done(clear_done),
    .wr_drop(wr_drop), .sat_flag(sat_flag), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t wv(input logic [AW-1:0] a, input bit c01, input bit c2, input bit acc,
                              input logic [DW-1:0] p0, input logic [DW-1:0] p1, input logic [DW-1:0] p2);
    vec_t v;
    v.rd = 1'b0; v.addr = a; v.c01 = c01; v.c2 = c2; v.acc = acc;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.exp = 64'h0;
    return v;
  endfunction

  function automatic vec_t rv(input logic [AW-1:0] a, input logic [2*DW-1:0] e);
    vec_t v;
    v.rd = 1'b1; v.addr = a; v.c01 = 1'b0; v.c2 = 1'b0; v.acc = 1'b0;
    v.p0 = 32'h0; v.p1 = 32'h0; v.p2 = 32'h0; v.exp = e;
    return v;
  endfunction

  // One write cycle, called at a negedge; returns at the next negedge.
  task automatic drive_wr(input logic [AW-1:0] a, input bit c01, input bit c2, input bit acc,
                          input logic [DW-1:0] p0, input logic [DW-1:0] p1, input logic [DW-1:0] p2);
    acc_wr_en = 1'b1; acc_wr_addr = a; acc_wr_col01 = c01; acc_wr_col2 = c2;
    acc_accumulate = acc; col0_psum = p0; col1_psum = p1; col2_psum = p2;
    @(negedge clk);
    acc_wr_en = 1'b0; acc_wr_col01 = 1'b0; acc_wr_col2 = 1'b0; acc_accumulate = 1'b0;
  endtask

  // Issue one read and queue its expected data once it is accepted.
  task automatic issue_rd(input logic [AW-1:0] a, input logic [2*DW-1:0] e);
    bit done = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = a;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rd_req_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
    end
    rd_req_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL rd_accept_timeout: addr %0d never accepted, expected ready 1", a);
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Scoreboard: compare each consumed read beat against the queue head.
  always @(negedge clk) begin
    #1;
    if (rst_n && rd_data_valid && rd_data_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_unexpected: got %h, expected no data", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    bit done_seen;

    rst_n = 1'b0; acc_wr_en = 1'b0; acc_wr_addr = '0; acc_wr_col01 = 1'b0; acc_wr_col2 = 1'b0;
    acc_clear = 1'b0; acc_accumulate = 1'b0; col0_psum = '0; col1_psum = '0; col2_psum = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_data_ready = 1'b1; err_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_data_valid", rd_data_valid, 1'b0);
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_acc_busy", acc_busy, 1'b0);
    check("rst_clear_done", clear_done, 1'b0);
    check("rst_wr_drop", wr_drop, 1'b0);
    check("rst_sat_flag", sat_flag, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clear sweep with a blocked write and an ignored re-trigger inside it
    acc_clear = 1'b1;
    busy_n = 0; done_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (acc_busy) busy_n++;
      if (clear_done) begin
        done_seen = 1'b1;
        break;
      end
      if (busy_n == 5) check("clear_rd_req_ready", rd_req_ready, 1'b0);
      if (busy_n == 10) begin
        acc_wr_en = 1'b1; acc_wr_addr = 9'd50; acc_wr_col01 = 1'b1;
        col0_psum = 32'h11; col1_psum = 32'h22;
      end
      if (busy_n == 11) begin
        acc_wr_en = 1'b0; acc_wr_col01 = 1'b0;
      end
      if (busy_n == 12) check("busy_write_drop", wr_drop, 1'b1);
      if (busy_n == 20) acc_clear = 1'b0;
      if (busy_n == 22) acc_clear = 1'b1;
    end
    check("clear_done_seen", done_seen, 1'b1);
    check("clear_busy_cycles", busy_n, 256);
    acc_clear = 1'b0;
    @(negedge clk);
    check("clear_done_pulse", clear_done, 1'b0);
    check("clear_busy_end", acc_busy, 1'b0);
    pulse_err_clr();
    check("wr_drop_cleared", wr_drop, 1'b0);

    // Table of back-to-back operations, one per cycle
    tbl.push_back(rv(9'd0,   64'h0));
    tbl.push_back(rv(9'd17,  64'h0));
    tbl.push_back(rv(9'd255, 64'h0));
    tbl.push_back(rv(9'd50,  64'h0));
    tbl.push_back(wv(9'd8,  1, 0, 0, 32'd5, 32'hFFFF_FFFD, 32'h0));
    tbl.push_back(wv(9'd9,  1, 0, 0, 32'd5, 32'hFFFF_FFFD, 32'h0));
    tbl.push_back(wv(9'd10, 0, 1, 0, 32'h0, 32'h0BAD_0BAD, 32'd7));
    tbl.push_back(rv(9'd8,  64'hFFFF_FFFD_0000_0005));
    tbl.push_back(rv(9'd9,  64'hFFFF_FFFD_0000_0005));
    tbl.push_back(rv(9'd10, 64'h0000_0000_0000_0007));
    tbl.push_back(wv(9'd4, 1, 0, 1, 32'd1, 32'd2, 32'h0));
    tbl.push_back(wv(9'd4, 1, 0, 1, 32'd1, 32'd2, 32'h0));
    tbl.push_back(wv(9'd4, 1, 0, 1, 32'd1, 32'd2, 32'h0));
    tbl.push_back(rv(9'd4,  64'h0000_0006_0000_0003));
    tbl.push_back(wv(9'd10, 0, 1, 1, 32'h0, 32'h1234_5678, 32'd3));
    tbl.push_back(rv(9'd10, 64'h0000_0000_0000_000A));
    tbl.push_back(wv(9'd11, 1, 0, 0, 32'hFFFF_FFFF, 32'd100, 32'h0));
    tbl.push_back(wv(9'd11, 1, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FF9C, 32'h0));
    tbl.push_back(rv(9'd11, 64'h0000_0000_FFFF_FFFD));
    foreach (tbl[k]) begin
      if (tbl[k].rd) issue_rd(tbl[k].addr, tbl[k].exp);
      else drive_wr(tbl[k].addr, tbl[k].c01, tbl[k].c2, tbl[k].acc, tbl[k].p0, tbl[k].p1, tbl[k].p2);
    end
    repeat (3) @(negedge clk);
    check("table_sat_flag", sat_flag, 1'b0);
    check("table_wr_drop", wr_drop, 1'b0);

    // Positive saturation, then err_clr
    drive_wr(9'd3, 1, 0, 0, 32'h7FFF_FFF0, 32'h0, 32'h0);
    drive_wr(9'd3, 1, 0, 1, 32'h0000_0020, 32'h0, 32'h0);
    @(negedge clk);
    check("sat_pos_flag", sat_flag, 1'b1);
    issue_rd(9'd3, 64'h0000_0000_7FFF_FFFF);
    pulse_err_clr();
    check("sat_clr", sat_flag, 1'b0);

    // Negative saturation with err_clr in the same cycle: the set wins
    drive_wr(9'd5, 1, 0, 0, 32'h8000_0010, 32'h0, 32'h0);
    drive_wr(9'd5, 1, 0, 1, 32'hFFFF_FFE0, 32'h0, 32'h0);
    pulse_err_clr();
    check("sat_set_beats_clr", sat_flag, 1'b1);
    issue_rd(9'd5, 64'h0000_0000_8000_0000);
    pulse_err_clr();
    check("sat_clr2", sat_flag, 1'b0);

    // Illegal writes leave memory untouched and raise wr_drop
    drive_wr(9'd20, 1, 1, 0, 32'h55, 32'h66, 32'h77);
    check("drop_both_sel", wr_drop, 1'b1);
    pulse_err_clr();
    check("drop_clr1", wr_drop, 1'b0);
    drive_wr(9'd21, 0, 0, 0, 32'h55, 32'h66, 32'h77);
    check("drop_no_sel", wr_drop, 1'b1);
    pulse_err_clr();
    drive_wr(9'd300, 1, 0, 0, 32'h55, 32'h66, 32'h77);
    check("drop_oob_addr", wr_drop, 1'b1);
    pulse_err_clr();
    check("drop_clr2", wr_drop, 1'b0);
    issue_rd(9'd20, 64'h0);
    issue_rd(9'd21, 64'h0);
    issue_rd(9'd44, 64'h0);
    issue_rd(9'd300, 64'h0);
    check("rd_oob_drop", wr_drop, 1'b1);
    pulse_err_clr();

    // Backpressure: data held, request not ready
    repeat (2) @(negedge clk);
    rd_data_ready = 1'b0;
    issue_rd(9'd8, 64'hFFFF_FFFD_0000_0005);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", rd_data_valid, 1'b1);
      check("bp_req_ready", rd_req_ready, 1'b0);
      check("bp_data_stable", rd_data, 64'hFFFF_FFFD_0000_0005);
      @(negedge clk);
    end
    rd_data_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Read in the same cycle W2 commits to that address
    drive_wr(9'd6, 1, 0, 0, 32'd1, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    drive_wr(9'd6, 1, 0, 0, 32'd9, 32'h0, 32'h0);
    issue_rd(9'd6, 64'h0000_0000_0000_0009);
    repeat (2) @(negedge clk);
    issue_rd(9'd6, 64'h0000_0000_0000_0009);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
